// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - state enum and JK excitation helper; JK_TOGGLE_PREF_EN selects X resolution
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    DRIVE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Value given to every don't-care entry of the excitation table.
  // With the macro defined the toggle code (11) gets used for 0->1 and 1->0.
`ifdef JK_TOGGLE_PREF_EN
  localparam logic JK_X_VAL = 1'b1;
`else
  localparam logic JK_X_VAL = 1'b0;
`endif

  // Excitation table: given present Q and desired next Q, return {j,k}.
  function automatic logic [1:0] jk_excite(input logic q, input logic d);
    logic j;
    logic k;
    case ({q, d})
      2'b00: begin j = 1'b0;     k = JK_X_VAL; end
      2'b01: begin j = 1'b1;     k = JK_X_VAL; end
      2'b10: begin j = JK_X_VAL; k = 1'b1;     end
      default: begin j = JK_X_VAL; k = 1'b0;   end
    endcase
    return {j, k};
  endfunction

endpackage

// File: rtl/jk_step_tick.sv
// rtl/jk_step_tick.sv - DIV_W-bit step divider with synchronous clear and all-ones tick
module jk_step_tick #(
  parameter int DIV_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Clear wins over count; the counter only advances while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = &cnt_q;

endmodule

// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - JK flip-flop pattern sequencer with Q check; JK_TOGGLE_PREF_EN in jk_pkg
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int DIV_W = 26,
  parameter int PAT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PAT_W-1:0]           pattern,
  input  logic                       q_fb,
  output logic                       j,
  output logic                       k,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(PAT_W)-1:0]   step,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int STEP_W = $clog2(PAT_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PAT_W - 1);

  state_e             state_q;
  state_e             state_d;
  logic               start_q;
  logic               start_rise;
  logic               capture;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-1:0]   pat_d;
  logic [STEP_W-1:0]  step_q;
  logic [STEP_W-1:0]  step_d;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;
  logic [1:0]         jk_q;
  logic [1:0]         jk_d;
  logic               want_bit;
  logic               tick;
  logic               div_en;
  logic               div_clr;

  // The button is level; only a low-to-high transition starts a run, and
  // only from IDLE or DONE. Edges during a run are dropped.
  assign start_rise = start & ~start_q;
  assign capture    = start_rise && ((state_q == IDLE) || (state_q == DONE));
  assign want_bit   = pat_q[step_q];

  jk_step_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (div_clr),
    .en_i   (div_en),
    .tick_o (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: WAIT for a full divider period, one DRIVE, one CHECK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (capture) state_d = WAIT;
      WAIT:       if (tick) state_d = DRIVE;
      DRIVE:      state_d = CHECK;
      CHECK:      state_d = (step_q == STEP_LAST) ? DONE : WAIT;
      default:    state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      WAIT, DRIVE, CHECK: busy = 1'b1;
      DONE:               done = 1'b1;
      default:            ;
    endcase
  end

  // Datapath next values: pattern capture, step index, error count, J/K.
  always_comb begin
    pat_d   = pat_q;
    step_d  = step_q;
    err_d   = err_q;
    jk_d    = 2'b00;
    div_en  = (state_q == WAIT);
    div_clr = capture || ((state_q == WAIT) && tick);
    if (capture) begin
      pat_d  = pattern;
      step_d = '0;
      err_d  = '0;
    end
    // J/K are computed from the Q present at the end of WAIT, so they are
    // a register output and q_fb never reaches j/k combinationally.
    if ((state_q == WAIT) && tick) begin
      jk_d = jk_excite(q_fb, want_bit);
    end
    // q_fb has had the whole CHECK cycle to settle after the DRIVE edge.
    if (state_q == CHECK) begin
      if ((q_fb != want_bit) && (err_q != {ERR_W{1'b1}})) begin
        err_d = err_q + 1'b1;
      end
      if (step_q != STEP_LAST) begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // Datapath registers; reset forces j/k low immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      pat_q   <= '0;
      step_q  <= '0;
      err_q   <= '0;
      jk_q    <= 2'b00;
    end else begin
      start_q <= start;
      pat_q   <= pat_d;
      step_q  <= step_d;
      err_q   <= err_d;
      jk_q    <= jk_d;
    end
  end

  assign j       = jk_q[1];
  assign k       = jk_q[0];
  assign step    = step_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// tb/tb_jk_excite_driver.sv - randomized self-checking bench with time-based reference model
module tb_jk_excite_driver;

  localparam int DIV_W  = 2;
  localparam int PAT_W  = 4;
  localparam int ERR_W  = 2;
  localparam int WAITN  = 1 << DIV_W;
  localparam int PERIOD = WAITN + 2;
  localparam int ERRMAX = (1 << ERR_W) - 1;

`ifdef JK_TOGGLE_PREF_EN
  localparam logic       X_RES   = 1'b1;
  localparam logic [7:0] JK_0110 = 8'b01_11_10_11;
`else
  localparam logic       X_RES   = 1'b0;
  localparam logic [7:0] JK_0110 = 8'b00_10_00_01;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       q_fb;
  logic       j, k, busy, done;
  logic [1:0] step;
  logic [1:0] err_cnt;
  logic       q_ff;
  logic       force0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_excite_driver #(
    .DIV_W (DIV_W),
    .PAT_W (PAT_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .q_fb    (q_fb),
    .j       (j),
    .k       (k),
    .busy    (busy),
    .done    (done),
    .step    (step),
    .err_cnt (err_cnt)
  );

  // behavioural JK flip-flop being driven
  always @(posedge clk or negedge reset) begin
    if (!reset) q_ff <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end
  assign q_fb = force0 ? 1'b0 : q_ff;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: time since capture decides the phase of each step
  logic       m_active, m_done, m_prev;
  logic [3:0] m_pat;
  logic [1:0] m_jk;
  int         m_t, m_err, m_checks;
  logic       start_s, qfb_s, reset_s;
  logic [3:0] pattern_s;

  function automatic logic [1:0] ref_excite(input logic q, input logic d);
    // q=0: j must equal d, k free; q=1: k must be ~d, j free
    return {(q ? X_RES : d), (q ? ~d : X_RES)};
  endfunction

  function automatic int exp_step();
    if (m_active) return m_t / PERIOD;
    return m_done ? PAT_W - 1 : 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_prev = 0; m_pat = 0;
    m_jk = 0; m_t = 0; m_err = 0;
  endtask

  initial begin
    model_reset();
    m_checks = 0;
    start_s = 0; qfb_s = 0; reset_s = 0; pattern_s = 0;
  end

  always @(posedge clk) begin
    if (!reset_s || !reset) model_reset();
    else begin
      logic edge_seen;
      edge_seen = start_s && !m_prev;
      m_prev = start_s;
      m_jk = 2'b00;
      if (m_active) begin
        if (m_t % PERIOD == PERIOD - 1) begin
          m_checks++;
          if (qfb_s != m_pat[m_t / PERIOD] && m_err < ERRMAX) m_err++;
          if (m_t / PERIOD == PAT_W - 1) begin
            m_active = 0;
            m_done = 1;
          end
        end
        if (m_active) begin
          m_t++;
          if (m_t % PERIOD == WAITN) m_jk = ref_excite(qfb_s, m_pat[m_t / PERIOD]);
        end
      end else if (edge_seen) begin
        m_active = 1; m_done = 0; m_t = 0; m_pat = pattern_s; m_err = 0;
      end
    end
  end

  // compare every cycle, then sample inputs for the next active edge
  always @(negedge clk) begin
    if (!reset) model_reset();
    chk("j", j, m_jk[1]);
    chk("k", k, m_jk[0]);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("step", step, exp_step());
    chk("err_cnt", err_cnt, m_err);
    start_s = start; pattern_s = pattern; qfb_s = q_fb; reset_s = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [3:0] pat, input logic f0, input bit mid_pulse,
                     input bit rnd_start, output logic [7:0] jk_h,
                     output logic [3:0] q_h, output logic [7:0] err_h, output int dcyc);
    int last_checks;
    start = 0; force0 = f0; pattern = pat;
    tick(2);
    start = 1;
    tick(1);
    start = 0;
    chk("capture_busy", busy, 1);
    chk("capture_step", step, 0);
    chk("capture_err", err_cnt, 0);
    dcyc = 0; jk_h = 0; q_h = 0; err_h = 0; last_checks = m_checks;
    while (!done && dcyc < 200) begin
      if (mid_pulse) start = (dcyc >= 8 && dcyc < 10);
      else if (rnd_start) start = ($urandom_range(0, 3) == 0);
      else start = 0;
      tick(1);
      dcyc++;
      if (m_active && m_t % PERIOD == WAITN) jk_h = {jk_h[5:0], j, k};
      if (m_active && m_t % PERIOD == PERIOD - 1) q_h = {q_fb, q_h[3:1]};
      if (m_checks != last_checks) begin
        err_h = {err_h[5:0], err_cnt};
        last_checks = m_checks;
      end
    end
    start = 0;
    if (!done) chk("done_timeout", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] jk_h;
    logic [3:0] q_h;
    logic [7:0] err_h;
    int         dcyc;
    int         n;

    // reset held while inputs move
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      start = ~start;
      pattern = 4'($urandom);
      tick(1);
    end
    chk("rst_j", j, 0); chk("rst_k", k, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_step", step, 0); chk("rst_err", err_cnt, 0);
    start = 0;
    tick(1);
    reset = 1;
    tick(2);

    // pattern 0110, Q follows, 24-cycle run
    run(4'b0110, 1'b0, 1'b0, 1'b0, jk_h, q_h, err_h, dcyc);
    chk("jk_0110", jk_h, JK_0110);
    chk("q_0110", q_h, 4'b0110);
    chk("err_0110", err_cnt, 0);
    chk("done_time_0110", dcyc, 24);

    // Q stuck low, all-ones pattern: error count saturates
    run(4'b1111, 1'b1, 1'b0, 1'b0, jk_h, q_h, err_h, dcyc);
    chk("err_hist_1111", err_h, 8'b01_10_11_11);
    chk("done_1111", done, 1);

    // restart from DONE with a start pulse ignored during step 1
    run(4'b1001, 1'b0, 1'b1, 1'b0, jk_h, q_h, err_h, dcyc);
    chk("q_1001", q_h, 4'b1001);
    chk("err_1001", err_cnt, 0);
    chk("done_time_1001", dcyc, 24);

    // reset asserted during DRIVE clears j/k at once (Q is 1, bit0 is 0)
    start = 0; force0 = 0; pattern = 4'b0000;
    tick(2);
    start = 1;
    tick(1);
    start = 0;
    n = 0;
    while (!(m_active && m_t % PERIOD == WAITN) && n < 20) begin
      tick(1);
      n++;
    end
    chk("drive_nonzero", int'(j | k), 1);
    reset = 0;
    #1;
    chk("async_j", j, 0);
    chk("async_k", k, 0);
    chk("async_busy", busy, 0);
    tick(2);
    reset = 1;
    tick(2);

    // randomized runs with start chatter
    for (int r = 0; r < 8; r++) begin
      run(4'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 1'b1, jk_h, q_h, err_h, dcyc);
      chk("rand_done_time", dcyc, 24);
      tick($urandom_range(0, 3));
    end
    force0 = 0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
